// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame-level receive controller placed behind a byte-oriented UART receiver.
// It hunts for a start-of-frame byte, then collects a length byte, the
// payload and an additive checksum, all under an inter-byte timeout. Payload
// bytes are buffered and only released downstream once the checksum has
// passed. Every rejected frame produces a one-cycle error pulse and a cause code.
//
// Payload stream handshake: pl_data and pl_last are meaningful only while
// pl_vld is high. A byte transfers on every rising clk edge where pl_vld and
// pl_rdy are both high. While pl_vld is high and pl_rdy is low, pl_data and
// pl_last hold their values, and pl_vld stays high until the transfer happens.
//
// state_dbg exposes the sequencer state:
// 0 = IDLE, 1 = LEN, 2 = PAYLOAD, 3 = CSUM, 4 = DRAIN.

module uart_rx_frame_ctrl #(
   parameter int unsigned clk_freq      = 50000000,
   parameter int unsigned baud_rate     = 19200,
   parameter int unsigned max_len       = 16,
   parameter logic [7:0]  sof_byte      = 8'hA5,
   parameter int unsigned timeout_bytes = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_data_vld,
   input  logic       parity_err,
   output logic [7:0] pl_data,
   output logic       pl_vld,
   output logic       pl_last,
   input  logic       pl_rdy,
   output logic [7:0] frame_len,
   output logic       frame_err,
   output logic [2:0] err_code,
   output logic       busy,
   output logic [2:0] state_dbg
);

   // Terminal count of the inter-byte timer. The arithmetic is done in
   // 64 bits so fast clocks and long timeouts cannot overflow it.
   localparam logic [63:0] TMO_LIMIT = 64'(timeout_bytes) * 64'd10 * 64'(clk_freq)
                                       / 64'(baud_rate) - 64'd1;
   localparam int TMR_W = $clog2(TMO_LIMIT) + 1;
   localparam logic [TMR_W-1:0] TMO_END = TMR_W'(TMO_LIMIT);

   // The buffer is rounded up to a power of two, so every index value
   // addresses a real entry.
   localparam int ADDR_W = (max_len > 1) ? $clog2(max_len) : 1;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [7:0] MAX_LEN_B = 8'(max_len);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_PARITY  = 3'd1;
   localparam logic [2:0] ERR_LEN     = 3'd2;
   localparam logic [2:0] ERR_CSUM    = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;
   localparam logic [2:0] ERR_OVERRUN = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CSUM    = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t           state;
   logic             vld_q;
   logic             accept;
   logic [7:0]       len_q;
   logic [7:0]       sum_q;
   logic [7:0]       csum_chk;
   logic [7:0]       wr_idx;
   logic [7:0]       wr_nx;
   logic [7:0]       rd_idx;
   logic [7:0]       rd_nx;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nx;
   logic             timed;
   logic             expired;
   logic             buf_we;
   logic [7:0]       pl_buf [DEPTH];

   // rx_data_vld is a level, so only its rising edge counts as a new byte.
   assign accept   = rx_data_vld & ~vld_q;

   // Running sum including the candidate checksum byte; zero means a good frame.
   assign csum_chk = sum_q + rx_data;
   assign wr_nx    = wr_idx + 8'd1;
   assign rd_nx    = rd_idx + 8'd1;

   // The timer runs only while a frame is being collected. An accepted byte
   // restarts it and also beats an expiry in the same cycle. Every entry into
   // a timed state comes from IDLE or from an accepted byte, so the timer
   // always starts from zero there.
   assign timed    = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
   assign expired  = timed && !accept && (timer == TMO_END);
   assign timer_nx = (timed && !accept && !expired) ? timer + TMR_W'(1) : '0;

   // A payload byte with bad parity is never written; its frame is dropped anyway.
   assign buf_we   = accept && (state == ST_PAYLOAD) && !parity_err;

   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Remember the previous level of rx_data_vld for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
      end else begin
         vld_q <= rx_data_vld;
      end
   end

   // Payload buffer write port. The content does not need a reset.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         pl_buf[wr_idx[ADDR_W-1:0]] <= rx_data;
      end
   end

   // Frame sequencer: SOF hunt, length/payload/checksum collection,
   // drain and error reporting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         len_q     <= '0;
         sum_q     <= '0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         timer     <= '0;
         pl_data   <= '0;
         pl_vld    <= 1'b0;
         pl_last   <= 1'b0;
         frame_len <= '0;
         frame_err <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         frame_err <= 1'b0;
         timer     <= timer_nx;

         case (state)
            ST_IDLE: begin
               // Anything other than a clean SOF byte is dropped silently.
               if (accept && (rx_data == sof_byte) && !parity_err) begin
                  state <= ST_LEN;
               end
            end

            ST_LEN: begin
               if (accept) begin
                  if (parity_err) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_PARITY;
                     state     <= ST_IDLE;
                  end else if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_LEN;
                     state     <= ST_IDLE;
                  end else begin
                     len_q  <= rx_data;
                     sum_q  <= rx_data;
                     wr_idx <= '0;
                     state  <= ST_PAYLOAD;
                  end
               end else if (expired) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  state     <= ST_IDLE;
               end
            end

            ST_PAYLOAD: begin
               if (accept) begin
                  if (parity_err) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_PARITY;
                     state     <= ST_IDLE;
                  end else begin
                     wr_idx <= wr_nx;
                     sum_q  <= sum_q + rx_data;
                     if (wr_nx == len_q) begin
                        state <= ST_CSUM;
                     end
                  end
               end else if (expired) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  state     <= ST_IDLE;
               end
            end

            ST_CSUM: begin
               if (accept) begin
                  if (parity_err) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_PARITY;
                     state     <= ST_IDLE;
                  end else if (csum_chk == 8'd0) begin
                     // Present the first byte straight away.
                     frame_len <= len_q;
                     rd_idx    <= '0;
                     pl_vld    <= 1'b1;
                     pl_data   <= pl_buf[ADDR_ZERO];
                     pl_last   <= (len_q == 8'd1);
                     state     <= ST_DRAIN;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_CSUM;
                     state     <= ST_IDLE;
                  end
               end else if (expired) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  state     <= ST_IDLE;
               end
            end

            ST_DRAIN: begin
               // A byte that arrives while the buffer is still draining is
               // lost. The drain itself continues untouched.
               if (accept) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_OVERRUN;
               end
               if (pl_vld && pl_rdy) begin
                  if (pl_last) begin
                     pl_vld  <= 1'b0;
                     pl_last <= 1'b0;
                     state   <= ST_IDLE;
                  end else begin
                     rd_idx  <= rd_nx;
                     pl_data <= pl_buf[rd_nx[ADDR_W-1:0]];
                     pl_last <= (rd_nx == (frame_len - 8'd1));
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
